// File: rtl/fpu_exc_status.sv
// Exception-status stage behind `except`: per-op IEEE flags, sticky accumulation, flag counter, optional irq.
// Latency: op issued in cycle T -> exc_valid/exc_flags/sticky/exc_cnt visible T+3, irq visible T+4.
// No backpressure: accepts one operation every cycle, never stalls.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   op_valid, fpu_op       issue strobe and opcode (0 add, 1 sub, 2 mul, 3 div, 4-7 no flags)
//   sign_a, sign_b         operand sign bits in the issue cycle
//   inf..opb_dn            operand classification from `except`, two cycles after issue
//   opa_nan, opb_nan       NaN classification from `except`, one cycle after issue
//   clr, clr_mask          single-cycle clear of selected sticky bits (all bits also clears exc_cnt)
//   irq_mask               interrupt enable per sticky bit
//   exc_valid, exc_flags   per-operation result strobe and flags {denorm, qnan, snan, divzero, invalid}
//   sticky, exc_cnt, irq   accumulated flags, saturating flagged-op count, interrupt request
//
// Build option: define FPU_EXC_IRQ_EN to build the interrupt register; otherwise irq is tied to 0.
module fpu_exc_status #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    input  logic [2:0]       fpu_op,
    input  logic             sign_a,
    input  logic             sign_b,
    input  logic             inf,
    input  logic             ind,
    input  logic             qnan,
    input  logic             snan,
    input  logic             opa_00,
    input  logic             opb_00,
    input  logic             opa_inf,
    input  logic             opb_inf,
    input  logic             opa_dn,
    input  logic             opb_dn,
    input  logic             opa_nan,
    input  logic             opb_nan,
    input  logic             clr,
    input  logic [4:0]       clr_mask,
    input  logic [4:0]       irq_mask,
    output logic             exc_valid,
    output logic [4:0]       exc_flags,
    output logic [4:0]       sticky,
    output logic [CNT_W-1:0] exc_cnt,
    output logic             irq
);

    localparam logic [2:0]       OP_ADD  = 3'd0;
    localparam logic [2:0]       OP_SUB  = 3'd1;
    localparam logic [2:0]       OP_MUL  = 3'd2;
    localparam logic [2:0]       OP_DIV  = 3'd3;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Alignment pipeline: issue-cycle information delayed to the cycle in
    // which `except` presents the matching classification bits.
    logic       vld_q1, vld_q2;
    logic [2:0] op_q1, op_q2;
    logic       esign_q1, esign_q2;
    logic       opa_nan_q;

    // Effective sign: for add the signs must differ, for sub they must match,
    // for inf-inf to be an invalid operation.
    logic esign_d;
    assign esign_d = sign_a ^ sign_b ^ (fpu_op == OP_SUB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q1    <= 1'b0;
            vld_q2    <= 1'b0;
            op_q1     <= 3'd0;
            op_q2     <= 3'd0;
            esign_q1  <= 1'b0;
            esign_q2  <= 1'b0;
            opa_nan_q <= 1'b0;
        end else begin
            vld_q1    <= op_valid;
            vld_q2    <= vld_q1;
            op_q1     <= fpu_op;
            op_q2     <= op_q1;
            esign_q1  <= esign_d;
            esign_q2  <= esign_q1;
            opa_nan_q <= opa_nan;
        end
    end

    // Flag derivation. Everything is gated by the aligned valid so that
    // undriven `except` outputs during idle cycles never reach the registers.
    logic       arith_op;
    logic       invalid_c;
    logic       divzero_c;
    logic       denorm_c;
    logic [4:0] new_flags;

    assign arith_op = vld_q2 & ~op_q2[2];

    always_comb begin
        invalid_c = 1'b0;
        divzero_c = 1'b0;
        case (op_q2)
            OP_ADD, OP_SUB: invalid_c = snan | (ind & esign_q2);
            OP_MUL:         invalid_c = snan | (opa_00 & opb_inf) | (opa_inf & opb_00);
            OP_DIV: begin
                invalid_c = snan | (opa_00 & opb_00) | ind;
                // x/0 with x finite, non-zero and not NaN
                divzero_c = opb_00 & ~opa_00 & ~opa_inf & ~opa_nan_q;
            end
            default: begin
                invalid_c = 1'b0;
                divzero_c = 1'b0;
            end
        endcase
    end

    // opX_dn from `except` is "exponent is zero", which includes true zeros.
    assign denorm_c = (opa_dn & ~opa_00) | (opb_dn & ~opb_00);

    always_comb begin
        new_flags = 5'd0;
        if (arith_op) begin
            new_flags = {denorm_c, qnan, snan, divzero_c, invalid_c};
        end
    end

    // Result register
    logic       exc_valid_q;
    logic [4:0] exc_flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_valid_q <= 1'b0;
            exc_flags_q <= 5'd0;
        end else begin
            exc_valid_q <= vld_q2;
            exc_flags_q <= new_flags;
        end
    end

    // Sticky register: new flags are OR-ed in after the clear, so a bit that
    // is set and cleared in the same cycle stays set.
    logic [4:0] sticky_q, sticky_d;
    logic [4:0] clr_bits;

    assign clr_bits = clr ? clr_mask : 5'd0;
    assign sticky_d = (sticky_q & ~clr_bits) | new_flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 5'd0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    // Flagged-operation counter. A full clear zeroes the base value first, so
    // a flagged op in the same cycle lands the counter on 1.
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
    logic             cnt_inc;

    assign cnt_inc  = |new_flags;
    assign cnt_base = (clr && (clr_mask == 5'b11111)) ? '0 : cnt_q;

    always_comb begin
        cnt_d = cnt_base;
        if (cnt_inc && (cnt_base != CNT_MAX)) begin
            cnt_d = cnt_base + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Interrupt: registered from the visible sticky bits, one cycle behind them.
    logic unused_inputs;

`ifdef FPU_EXC_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(sticky_q & irq_mask);
        end
    end

    assign irq           = irq_q;
    assign unused_inputs = ^{inf, opb_nan};
`else
    assign irq           = 1'b0;
    assign unused_inputs = ^{inf, opb_nan, irq_mask};
`endif

    assign exc_valid = exc_valid_q;
    assign exc_flags = exc_flags_q;
    assign sticky    = sticky_q;
    assign exc_cnt   = cnt_q;

endmodule
